mario_sprite_fetch: RTL and testbench
=====================================

Name: mario_sprite_fetch

Overview:
- Pipelined sprite pixel fetcher that sits directly upstream of the per-pose sprite ROMs (9-bit read address, 12-bit palette colour out, combinational) and directly upstream of the colour mapper.
- Per pixel, it decides whether the VGA beam is inside Mario's 20x22 box.
- It generates the ROM address and pose select, and returns the registered colour with an opacity flag (palette key 12'h808 = transparent).
- It owns the pose/animation state machine, updated once per video frame.

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 22, sprite height in pixels
- ADDR_W, 9, ROM address width (SPR_W*SPR_H <= 2**ADDR_W)
- KEY_COLOR, 12'h808, transparent palette colour
- WALK_PERIOD, 6, frames per walk-pose toggle (>=1)

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- pixel_en  input  1  one-cycle strobe: DrawX/DrawY valid
- frame_start  input  1  one-cycle strobe at start of vertical blank
- DrawX  input  10  beam column
- DrawY  input  10  beam row
- MarioX  input  10  sprite top-left column (sampled at frame_start)
- MarioY  input  10  sprite top-left row (sampled at frame_start)
- facing_left  input  1  sampled at frame_start
- walking  input  1  sampled at frame_start
- jumping  input  1  sampled at frame_start
- rom_addr  output  ADDR_W  read_address to selected sprite ROM
- rom_sel  output  3  {left, pose[1:0]}; pose 0=STAND 1=WALK1 2=WALK2 3=JUMP
- rom_color  input  12  output_color from selected ROM (combinational on rom_addr/rom_sel)
- pix_valid  output  1  pix_color/pix_opaque valid
- pix_color  output  12  fetched colour
- pix_opaque  output  1  pixel inside box and colour != KEY_COLOR

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-low (Reset_n).
- Reset values: all outputs 0; pose=STAND; walk counter 0; latched X/Y/facing/walking/jumping 0; pipeline valids 0.
- Frame latch: on frame_start, register MarioX, MarioY, facing_left, walking and jumping, and update the pose FSM.
  - Pixels in the same cycle as frame_start use the pre-update values.
- Pose FSM, evaluated only on frame_start with the newly sampled inputs:
  - jumping=1 -> JUMP, counter cleared.
  - Else walking=1:
    - From STAND or JUMP -> WALK1, counter 0.
    - From WALK1/WALK2: counter increments. When it reaches WALK_PERIOD-1, toggle WALK1<->WALK2 and clear the counter.
  - Else -> STAND, counter cleared.
  - Jumping has priority over walking.
- Stage 1 (cycle after pixel_en):
  - relX = DrawX-X, relY = DrawY-Y.
  - Compute in 11 bits, zero-extended, no wrap.
  - hit = DrawX>=X && DrawX<X+SPR_W && DrawY>=Y && DrawY<Y+SPR_H.
  - Box extending past 1023 is clipped, never wrapped.
  - On hit: rom_addr = relY*SPR_W + colX (colX = relX, or SPR_W-1-relX when mirrored). On miss: rom_addr = 0.
  - rom_sel is updated; hit_d1 and valid_d1 are registered.
  - Without pixel_en: valid_d1=0, rom_addr/rom_sel hold.
- Stage 2 (second cycle after pixel_en):
  - pix_color = rom_color if hit_d1, else 0.
  - pix_opaque = hit_d1 && rom_color != KEY_COLOR.
  - pix_valid = valid_d1.
- Latency: exactly 2 Clk from pixel_en to pix_valid.
- Throughput: one pixel per cycle (back-to-back pixel_en allowed).
- Reset asserted mid-line: outputs clear immediately (asynchronously). The first valid output after release is 2 cycles after the first subsequent pixel_en.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- Defined:
  - Only right-facing ROMs exist.
  - rom_sel[2] is forced to 0.
  - Latched facing_left=1 mirrors the column: colX = SPR_W-1-relX.
- Undefined:
  - rom_sel[2] = latched facing_left (separate left ROMs).
  - colX = relX always.

Test Plan:
- Frame latch X=100, Y=200, right, STAND; pixel_en with DrawX=105, DrawY=203 -> after 1 cycle rom_addr=65, rom_sel=0; after 2 cycles pix_valid=1. rom_color=12'hF30 -> pix_color=12'hF30, pix_opaque=1.
- Same as above with facing_left=1:
  - SPRITE_MIRROR_EN defined -> rom_addr=74, rom_sel=0.
  - Undefined -> rom_addr=65, rom_sel=4.
- rom_color=12'h808 on a hit -> pix_opaque=0, pix_color=12'h808.
- DrawX=99 or DrawY=222 with the box at 100,200 -> rom_addr=0, pix_color=0, pix_opaque=0, pix_valid=1.
- walking=1 held for 13 frame_start pulses (WALK_PERIOD=6):
  - pose after frame 1 = WALK1, after frame 7 = WALK2, after frame 13 = WALK1.
  - Then jumping=1 -> JUMP.
  - Then both low -> STAND.
- Box clipping: X=1015, DrawX=1023 -> hit, relX=8.
- Continuous pixel_en stream with Reset_n pulsed low for 1 cycle mid-stream -> outputs and pose are 0 immediately; pix_valid returns 2 cycles after the next pixel_en.

Source files
------------

// File: rtl/mario_sprite_fetch.sv
// ---------------------------------------------------------------------------
// mario_sprite_fetch
//   Two-stage pixel fetcher for Mario's sprite. Stage 1 tests whether the
//   beam is inside the SPR_W x SPR_H box and issues the ROM address/pose
//   select. Stage 2 registers the ROM colour with an opacity flag. The pose
//   / walk-animation FSM advances once per frame on frame_start.
//
//   Optional build macro: SPRITE_MIRROR_EN
//     defined   -> only right-facing ROMs; rom_sel[2]=0, column mirrored
//                  when the latched facing_left is set.
//     undefined -> rom_sel[2] selects the separate left-facing ROMs.
//
// Ports
//   Clk, Reset_n       clock, asynchronous active-low reset
//   pixel_en           DrawX/DrawY valid strobe
//   frame_start        start-of-vblank strobe; latches Mario state
//   DrawX, DrawY       beam position
//   MarioX, MarioY     sprite top-left (latched on frame_start)
//   facing_left, walking, jumping   pose controls (latched on frame_start)
//   rom_addr, rom_sel  sprite ROM read address / {left, pose}
//   rom_color          combinational ROM data
//   pix_valid, pix_color, pix_opaque   fetched pixel, 2 cycles after pixel_en
// ---------------------------------------------------------------------------
module mario_sprite_fetch #(
    parameter int          SPR_W       = 20,
    parameter int          SPR_H       = 22,
    parameter int          ADDR_W      = 9,
    parameter logic [11:0] KEY_COLOR   = 12'h808,
    parameter int          WALK_PERIOD = 6
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pixel_en,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        MarioX,
    input  logic [9:0]        MarioY,
    input  logic              facing_left,
    input  logic              walking,
    input  logic              jumping,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        rom_sel,
    input  logic [11:0]       rom_color,
    output logic              pix_valid,
    output logic [11:0]       pix_color,
    output logic              pix_opaque
);

    typedef enum logic [1:0] {
        STAND = 2'd0,
        WALK1 = 2'd1,
        WALK2 = 2'd2,
        JUMP  = 2'd3
    } pose_t;

    localparam int                CNT_W    = (WALK_PERIOD > 1) ? $clog2(WALK_PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WALK_PERIOD - 1);
    localparam logic [ADDR_W-1:0] SPR_W_A  = ADDR_W'(SPR_W);

    // Frame-latched sprite state
    logic [9:0]        r_x, r_y;
    logic              r_left, r_walk, r_jump;
    pose_t             r_pose, w_pose_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    // Pipeline state; r_vld[0] = stage-1 valid, r_vld[1] = output valid
    logic [1:0]        r_vld;
    logic              r_hit_d1;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [2:0]        r_rom_sel;
    logic [11:0]       r_pix_color;
    logic              r_pix_opaque;

    // -----------------------------------------------------------------------
    // Frame latch
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_left <= 1'b0;
            r_walk <= 1'b0;
            r_jump <= 1'b0;
        end else if (frame_start) begin
            r_x    <= MarioX;
            r_y    <= MarioY;
            r_left <= facing_left;
            r_walk <= walking;
            r_jump <= jumping;
        end
    end

    // -----------------------------------------------------------------------
    // Pose FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pose <= STAND;
            r_cnt  <= '0;
        end else begin
            r_pose <= w_pose_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // The FSM acts on the values being latched this frame_start, not on the
    // previous frame's latched copies.
    logic w_walk_s, w_jump_s;
    assign w_walk_s = frame_start ? walking : r_walk;
    assign w_jump_s = frame_start ? jumping : r_jump;

    always_comb begin
        w_pose_nxt = r_pose;
        w_cnt_nxt  = r_cnt;
        if (frame_start) begin
            if (w_jump_s) begin
                w_pose_nxt = JUMP;
                w_cnt_nxt  = '0;
            end else if (w_walk_s) begin
                case (r_pose)
                    STAND, JUMP: begin
                        w_pose_nxt = WALK1;
                        w_cnt_nxt  = '0;
                    end
                    default: begin
                        // Counter at its last value means this frame toggles.
                        if (r_cnt == CNT_LAST) begin
                            w_pose_nxt = (r_pose == WALK1) ? WALK2 : WALK1;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                endcase
            end else begin
                w_pose_nxt = STAND;
                w_cnt_nxt  = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: box test and ROM address
    // -----------------------------------------------------------------------
    // 11-bit compares so a box hanging past column/row 1023 clips, not wraps.
    logic [10:0]       w_dx, w_dy, w_x, w_y;
    logic              w_hit;
    logic [ADDR_W-1:0] w_rel_x, w_rel_y, w_col_x, w_addr;
    logic [2:0]        w_sel;

    assign w_dx  = {1'b0, DrawX};
    assign w_dy  = {1'b0, DrawY};
    assign w_x   = {1'b0, r_x};
    assign w_y   = {1'b0, r_y};
    assign w_hit = (w_dx >= w_x) && (w_dx < w_x + 11'(SPR_W)) &&
                   (w_dy >= w_y) && (w_dy < w_y + 11'(SPR_H));

    // Offsets only matter on a hit, where they are below SPR_W/SPR_H.
    assign w_rel_x = ADDR_W'(DrawX - r_x);
    assign w_rel_y = ADDR_W'(DrawY - r_y);

`ifdef SPRITE_MIRROR_EN
    assign w_col_x = r_left ? (SPR_W_A - 1'b1 - w_rel_x) : w_rel_x;
    assign w_sel   = {1'b0, r_pose};
`else
    assign w_col_x = w_rel_x;
    assign w_sel   = {r_left, r_pose};
`endif

    assign w_addr = w_rel_y * SPR_W_A + w_col_x;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_rom_sel  <= '0;
            r_hit_d1   <= 1'b0;
        end else if (pixel_en) begin
            r_rom_addr <= w_hit ? w_addr : '0;
            r_rom_sel  <= w_sel;
            r_hit_d1   <= w_hit;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: colour capture (holds between valid pixels)
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vld        <= '0;
            r_pix_color  <= '0;
            r_pix_opaque <= 1'b0;
        end else begin
            r_vld <= {r_vld[0], pixel_en};
            if (r_vld[0]) begin
                r_pix_color  <= r_hit_d1 ? rom_color : 12'h000;
                r_pix_opaque <= r_hit_d1 && (rom_color != KEY_COLOR);
            end
        end
    end

    assign rom_addr   = r_rom_addr;
    assign rom_sel    = r_rom_sel;
    assign pix_valid  = r_vld[1];
    assign pix_color  = r_pix_color;
    assign pix_opaque = r_pix_opaque;

endmodule

// File: tb/tb_mario_sprite_fetch.sv
module tb_mario_sprite_fetch;
    localparam int SPR_W = 20;
    localparam int SPR_H = 22;
    localparam int WP    = 6;

    logic        Clk = 1'b0, Reset_n = 1'b0, pixel_en = 1'b0, frame_start = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, MarioX = '0, MarioY = '0;
    logic        facing_left = 1'b0, walking = 1'b0, jumping = 1'b0;
    logic [8:0]  rom_addr;
    logic [2:0]  rom_sel;
    logic [11:0] rom_color;
    logic        pix_valid;
    logic [11:0] pix_color;
    logic        pix_opaque;

    logic        force_en = 1'b0;
    logic [11:0] force_col = '0;

    always #5 Clk = ~Clk;

    mario_sprite_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
        .facing_left(facing_left), .walking(walking), .jumping(jumping),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_color(rom_color),
        .pix_valid(pix_valid), .pix_color(pix_color), .pix_opaque(pix_opaque)
    );

    // Synthetic ROM contents; some addresses hold the key colour.
    function automatic logic [11:0] rom_fn(input logic [2:0] s, input logic [8:0] a);
        if (a[3:0] == 4'h5) return 12'h808;
        return {s, a} ^ 12'h5A5;
    endfunction

    assign rom_color = force_en ? force_col : rom_fn(rom_sel, rom_addr);

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_x, m_y, m_pose, m_cnt, m_addr, m_sel, m_c1, e_col;
    bit m_left, m_v1, m_h1, e_pv, e_op;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_left = 0; m_pose = 0; m_cnt = 0;
        m_addr = 0; m_sel = 0; m_v1 = 0; m_h1 = 0; e_pv = 0; e_col = 0; e_op = 0;
    endtask

    // One clock: drive, advance model, check everything the model knows.
    task automatic step(input bit pe, input bit fs, input int dx, input int dy,
                        input int mx, input int my, input bit fl, input bit wk, input bit jp);
        int relx, rely, colx;
        bit hit;
        pixel_en = pe; frame_start = fs; DrawX = 10'(dx); DrawY = 10'(dy);
        MarioX = 10'(mx); MarioY = 10'(my); facing_left = fl; walking = wk; jumping = jp;

        m_c1 = force_en ? int'(force_col) : int'(rom_fn(3'(m_sel), 9'(m_addr)));
        e_pv = m_v1;
        if (m_v1) begin
            e_col = m_h1 ? m_c1 : 0;
            e_op  = m_h1 && (m_c1 != 'h808);
        end

        if (pe) begin
            hit  = dx >= m_x && dx < m_x + SPR_W && dy >= m_y && dy < m_y + SPR_H;
            relx = dx - m_x;
            rely = dy - m_y;
`ifdef SPRITE_MIRROR_EN
            colx  = m_left ? SPR_W - 1 - relx : relx;
            m_sel = m_pose;
`else
            colx  = relx;
            m_sel = (m_left ? 4 : 0) + m_pose;
`endif
            m_addr = hit ? rely * SPR_W + colx : 0;
            m_h1   = hit;
        end
        m_v1 = pe;

        if (fs) begin
            m_x = mx; m_y = my; m_left = fl;
            if (jp) begin m_pose = 3; m_cnt = 0; end
            else if (wk) begin
                if (m_pose == 0 || m_pose == 3) begin m_pose = 1; m_cnt = 0; end
                else if (m_cnt == WP - 1) begin m_pose = 3 - m_pose; m_cnt = 0; end
                else m_cnt++;
            end else begin m_pose = 0; m_cnt = 0; end
        end

        @(posedge Clk); #1;
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("rom_sel", 32'(rom_sel), 32'(m_sel));
        chk("pix_valid", 32'(pix_valid), 32'(e_pv));
        if (e_pv) begin
            chk("pix_color", 32'(pix_color), 32'(e_col));
            chk("pix_opaque", 32'(pix_opaque), 32'(e_op));
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic latch(input int mx, input int my, input bit fl, input bit wk, input bit jp);
        step(0, 1, 0, 0, mx, my, fl, wk, jp);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int mx; int my; bit fl;
        int dx; int dy; logic [11:0] col;
        int e_addr; int e_sel; logic [11:0] e_col; bit e_op;
    } vec_t;

    vec_t tv[13];

    initial begin
        int pmx, pmy, dx, dy;
        bit pfl;

        // right-facing, STAND, box at (100,200)
        tv[0]  = '{100, 200, 0, 105, 203, 12'hF30,  65, 0, 12'hF30, 1};
        tv[1]  = '{100, 200, 0, 105, 203, 12'h808,  65, 0, 12'h808, 0};
        tv[2]  = '{100, 200, 0,  99, 203, 12'hF30,   0, 0, 12'h000, 0};
        tv[3]  = '{100, 200, 0, 105, 222, 12'hF30,   0, 0, 12'h000, 0};
        tv[4]  = '{100, 200, 0, 100, 200, 12'h0AB,   0, 0, 12'h0AB, 1};
        tv[5]  = '{100, 200, 0, 119, 221, 12'h123, 439, 0, 12'h123, 1};
        tv[6]  = '{100, 200, 0, 120, 210, 12'h123,   0, 0, 12'h000, 0};
        tv[7]  = '{100, 200, 0, 100, 221, 12'h7F0, 420, 0, 12'h7F0, 1};
        // facing left
`ifdef SPRITE_MIRROR_EN
        tv[8]  = '{100, 200, 1, 105, 203, 12'hF30,  74, 0, 12'hF30, 1};
        tv[9]  = '{100, 200, 1, 119, 221, 12'h456, 420, 0, 12'h456, 1};
`else
        tv[8]  = '{100, 200, 1, 105, 203, 12'hF30,  65, 4, 12'hF30, 1};
        tv[9]  = '{100, 200, 1, 119, 221, 12'h456, 439, 4, 12'h456, 1};
`endif
        // clipping at the right screen edge
        tv[10] = '{1015, 0, 0, 1023,  0, 12'hF30,   8, 0, 12'hF30, 1};
        tv[11] = '{1015, 0, 0, 1014,  0, 12'hF30,   0, 0, 12'h000, 0};
        tv[12] = '{1015, 0, 0, 1023, 21, 12'h0F0, 428, 0, 12'h0F0, 1};

        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_addr", 32'(rom_addr), 0);
        chk("reset_sel", 32'(rom_sel), 0);
        chk("reset_valid", 32'(pix_valid), 0);
        chk("reset_color", 32'(pix_color), 0);
        chk("reset_opaque", 32'(pix_opaque), 0);
        Reset_n = 1'b1;

        // ---- table ----
        pmx = -1; pmy = -1; pfl = 0;
        for (int i = 0; i < 13; i++) begin
            if (tv[i].mx != pmx || tv[i].my != pmy || tv[i].fl != pfl) begin
                latch(tv[i].mx, tv[i].my, tv[i].fl, 0, 0);
                pmx = tv[i].mx; pmy = tv[i].my; pfl = tv[i].fl;
            end
            force_en = 1'b1; force_col = tv[i].col;
            step(1, 0, tv[i].dx, tv[i].dy, 0, 0, 0, 0, 0);
            chk("tv_addr", 32'(rom_addr), 32'(tv[i].e_addr));
            chk("tv_sel", 32'(rom_sel), 32'(tv[i].e_sel));
            chk("tv_lat1_valid", 32'(pix_valid), 0);
            idle();
            chk("tv_valid", 32'(pix_valid), 1);
            chk("tv_color", 32'(pix_color), 32'(tv[i].e_col));
            chk("tv_opaque", 32'(pix_opaque), 32'(tv[i].e_op));
        end
        force_en = 1'b0;

        // ---- pixel in the frame_start cycle uses the old box ----
        latch(100, 200, 0, 0, 0);
        step(1, 1, 105, 203, 300, 300, 0, 0, 0);
        chk("fs_same_cycle_addr", 32'(rom_addr), 65);
        step(1, 0, 305, 303, 0, 0, 0, 0, 0);
        chk("fs_new_box_addr", 32'(rom_addr), 65);

        // ---- walk animation ----
        for (int f = 1; f <= 13; f++) begin
            latch(100, 200, 0, 1, 0);
            step(1, 0, 105, 203, 0, 0, 0, 0, 0);
            if (f == 1 || f == 6 || f == 13) chk("walk_pose1", 32'(rom_sel), 1);
            if (f == 7 || f == 12) chk("walk_pose2", 32'(rom_sel), 2);
        end
        latch(100, 200, 0, 1, 1);
        step(1, 0, 105, 203, 0, 0, 0, 0, 0);
        chk("jump_pose", 32'(rom_sel), 3);
        latch(100, 200, 0, 1, 0);
        step(1, 0, 105, 203, 0, 0, 0, 0, 0);
        chk("jump_to_walk", 32'(rom_sel), 1);
        latch(100, 200, 0, 0, 0);
        step(1, 0, 105, 203, 0, 0, 0, 0, 0);
        chk("stand_pose", 32'(rom_sel), 0);

        // ---- reset pulse mid-stream ----
        latch(100, 200, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 105 + i, 203, 0, 0, 0, 0, 0);
        Reset_n = 1'b0;
        #2;
        chk("mid_reset_addr", 32'(rom_addr), 0);
        chk("mid_reset_sel", 32'(rom_sel), 0);
        chk("mid_reset_valid", 32'(pix_valid), 0);
        chk("mid_reset_color", 32'(pix_color), 0);
        chk("mid_reset_opaque", 32'(pix_opaque), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model_reset();
        idle();
        step(1, 0, 5, 3, 0, 0, 0, 0, 0);
        chk("post_reset_addr", 32'(rom_addr), 65);
        chk("post_reset_pose", 32'(rom_sel), 0);
        chk("post_reset_lat1", 32'(pix_valid), 0);
        idle();
        chk("post_reset_lat2", 32'(pix_valid), 1);

        // ---- randomized stream against the model ----
        for (int n = 0; n < 600; n++) begin
            dx = m_x + int'($urandom_range(0, SPR_W + 7)) - 3;
            dy = m_y + int'($urandom_range(0, SPR_H + 7)) - 3;
            if (dx < 0) dx = 0;
            if (dx > 1023) dx = 1023;
            if (dy < 0) dy = 0;
            if (dy > 1023) dy = 1023;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, dx, dy,
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
